bpred_btb: RTL and testbench
============================

BPRED_BTB -- requirements
Module: bpred_btb

Interface
REQ-001 SHALL have parameter NENTRIES, default 64, meaning BTB entries (power of two, >=2); IDX_W = log2(NENTRIES).
REQ-002 SHALL have parameter TAG_W, default 10, meaning stored PC tag bits.
REQ-003 SHALL have parameter CNT_W, default 2, meaning saturating direction counter width (>=1).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1  fetch request valid.
- ready  in  1  fetch accepts prediction.
- pc  in  pc_t  fetch PC.
- prediction_0  out  bp_t  0-cycle prediction {pcnext, taken}.
- upd_valid  in  1  resolved-branch update from execute.
- upd_pc  in  pc_t  PC of resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  pc_t  resolved target.
- flush  in  1  invalidate all entries.
- perf_hits  out  32  count of accepted lookups that hit.

Function
REQ-005 SHALL derive idx = pc[IDX_W+1:2] and tag = pc[IDX_W+2 +: TAG_W]; upd_pc is decoded identically.
REQ-006 SHALL store per entry: valid bit, tag, target (pc_t), CNT_W-bit counter; direct-mapped.
REQ-007 SHALL compute hit = entry[idx].valid && entry[idx].tag == tag, combinationally from current state, with zero-cycle latency.
REQ-008 SHALL drive prediction_0.taken = hit && counter MSB; prediction_0.pcnext = taken ? entry target : pc + 4 (pc_t width, wrap-around modulo 2^width).
REQ-009 SHALL update state on the rising edge after upd_valid=1 as follows.
- On an update hit with upd_taken=1: counter increments, saturating at all-ones; target is overwritten with upd_target.
- On an update hit with upd_taken=0: counter decrements, saturating at 0; target is unchanged.
- On an update miss with upd_taken=1: the entry is allocated (valid=1, tag written, target=upd_target, counter=weakly taken, i.e. MSB=1, rest 0), replacing any occupant.
- On an update miss with upd_taken=0: no state change.
REQ-010 SHALL NOT bypass updates to lookups: a same-cycle lookup and update to the same idx sees the pre-update entry.
REQ-011 SHALL clear all valid bits on the edge after flush=1; flush takes priority over a simultaneous upd_valid, and that update is discarded.
REQ-012 SHALL increment perf_hits by 1 on each edge where valid && ready && hit; the counter wraps from 2^32-1 to 0; flush does not clear it.
REQ-013 SHALL ignore valid/ready for prediction_0 generation; they gate only perf_hits.

Reset
REQ-014 SHALL clear all valid bits and perf_hits to 0 on the edge where rst=1; tag, target and counter arrays need no reset.
REQ-015 SHALL have reset dominate flush and upd_valid in the same cycle.
REQ-016 SHALL, while rst=1 and after release, output taken=0 and pcnext=pc+4 until the first allocation.

Structure
REQ-017 SHALL take pc_t and bp_t from package C; package C SHALL add the btb_entry_t struct and the BTB_NENTRIES/BTB_TAG_W defaults.
REQ-018 SHALL place the saturating counter update in one sub-module, sat_counter (combinational next-value, parametrised width).

Verification
REQ-019 SHALL cover a cold lookup: after reset, pc=0x1000 -> taken=0, pcnext=0x1004, perf_hits=0.
REQ-020 SHALL cover allocation: upd pc=0x1000, taken=1, target=0x2000; next cycle lookup pc=0x1000 -> taken=1, pcnext=0x2000; with valid=ready=1 -> perf_hits=1.
REQ-021 SHALL cover hysteresis: starting from an allocated entry at counter 2'b10, two not-taken updates -> counter 0, prediction not taken; three taken updates -> counter 3 (saturated), prediction taken.
REQ-022 SHALL cover aliasing: allocate 0x1000, then update taken at 0x1000 + 4*NENTRIES with target 0x3000 -> lookup 0x1000 misses; lookup of the alias predicts 0x3000.
REQ-023 SHALL cover collisions: flush and upd_valid in the same cycle -> all lookups miss next cycle; a same-cycle lookup/update to one idx returns the old entry.
REQ-024 SHALL cover reset mid-operation: rst asserted with upd_valid=1 -> next cycle all lookups miss and perf_hits=0.

Source files
------------

// File: rtl/bpred_btb_pkg.sv
// rtl/bpred_btb_pkg.sv - shared types and defaults for the branch target buffer
package bpred_btb_pkg;

  localparam int PC_W         = 32;
  localparam int BTB_NENTRIES = 64;
  localparam int BTB_TAG_W    = 10;
  localparam int BTB_CNT_W    = 2;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    pc_t  pcnext;
    logic taken;
  } bp_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    pc_t                  target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - combinational next value of a saturating up/down counter
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (inc && (cnt != {W{1'b1}})) begin
      nxt = cnt + W'(1);
    end else if (!inc && (cnt != {W{1'b0}})) begin
      nxt = cnt - W'(1);
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - direct-mapped BTB with zero-cycle prediction and per-entry direction counters
module bpred_btb
  import bpred_btb_pkg::*;
#(
  parameter int NENTRIES = BTB_NENTRIES,
  parameter int TAG_W    = BTB_TAG_W,
  parameter int CNT_W    = BTB_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        ready,
  input  pc_t         pc,
  output bp_t         prediction_0,
  input  logic        upd_valid,
  input  pc_t         upd_pc,
  input  logic        upd_taken,
  input  pc_t         upd_target,
  input  logic        flush,
  output logic [31:0] perf_hits
);

  localparam int IDX_W = $clog2(NENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [NENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q    [NENTRIES];
  pc_t                 target_q [NENTRIES];
  logic [CNT_W-1:0]    cnt_q    [NENTRIES];

  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             hit, upd_hit;
  logic [CNT_W-1:0] cnt_nxt;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[IDX_W+2 +: TAG_W];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];

  logic unused_upd_bits;
  assign unused_upd_bits = ^{upd_pc[1:0], upd_pc[PC_W-1:IDX_W+2+TAG_W]};

  // Lookup reads only registered state, so a same-cycle update is never visible here.
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    prediction_0.taken  = hit && cnt_q[idx][CNT_W-1];
    prediction_0.pcnext = prediction_0.taken ? target_q[idx] : pc + pc_t'(4);
  end

  sat_counter #(.W(CNT_W)) u_sat_counter (
    .cnt (cnt_q[upd_idx]),
    .inc (upd_taken),
    .nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else if (upd_valid && !upd_hit && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays are not reset; valid_q alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush && upd_valid) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= cnt_nxt;
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        cnt_q[upd_idx]    <= CNT_WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits <= '0;
    end else if (valid && ready && hit) begin
      perf_hits <= perf_hits + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// tb/tb_bpred_btb.sv - directed self-checking bench for bpred_btb
module tb_bpred_btb;
  import bpred_btb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  pc_t         pc;
  bp_t         prediction_0;
  logic        upd_valid;
  pc_t         upd_pc;
  logic        upd_taken;
  pc_t         upd_target;
  logic        flush;
  logic [31:0] perf_hits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpred_btb dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .ready        (ready),
    .pc           (pc),
    .prediction_0 (prediction_0),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .flush        (flush),
    .perf_hits    (perf_hits)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic predict(input string name, input pc_t lpc, input logic exp_taken, input pc_t exp_next);
    pc = lpc;
    #1;
    check({name, ".taken"}, 64'(prediction_0.taken), 64'(exp_taken));
    check({name, ".pcnext"}, 64'(prediction_0.pcnext), 64'(exp_next));
  endtask

  task automatic update(input pc_t upc, input logic taken, input pc_t target);
    upd_pc     = upc;
    upd_taken  = taken;
    upd_target = target;
    upd_valid  = 1'b1;
    tick();
    upd_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b0; pc = 32'h1000;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
    tick();
    predict("in_reset", 32'h1000, 1'b0, 32'h1004);
    check("in_reset.perf", 64'(perf_hits), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // cold lookup, including 32-bit wrap of pc+4
    predict("cold", 32'h1000, 1'b0, 32'h1004);
    check("cold.perf", 64'(perf_hits), 64'd0);
    predict("cold_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // allocation: weakly taken
    update(32'h1000, 1'b1, 32'h2000);
    predict("alloc", 32'h1000, 1'b1, 32'h2000);
    valid = 1'b1; ready = 1'b1;
    tick();
    valid = 1'b0; ready = 1'b0;
    check("alloc.perf", 64'(perf_hits), 64'd1);

    // hysteresis: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
    update(32'h1000, 1'b0, 32'h0);
    predict("hyst_c1", 32'h1000, 1'b0, 32'h1004);
    update(32'h1000, 1'b0, 32'h0);
    predict("hyst_c0", 32'h1000, 1'b0, 32'h1004);
    update(32'h1000, 1'b0, 32'h0);
    update(32'h1000, 1'b1, 32'h2000);
    predict("hyst_sat0_c1", 32'h1000, 1'b0, 32'h1004);
    update(32'h1000, 1'b1, 32'h2000);
    predict("hyst_c2", 32'h1000, 1'b1, 32'h2000);
    update(32'h1000, 1'b1, 32'h2000);
    update(32'h1000, 1'b1, 32'h2000);
    update(32'h1000, 1'b0, 32'h0);
    predict("hyst_sat3_c2", 32'h1000, 1'b1, 32'h2000);
    update(32'h1000, 1'b0, 32'h0);
    predict("hyst_c1b", 32'h1000, 1'b0, 32'h1004);

    // aliasing: 0x1100 shares idx 0 with 0x1000 but has a different tag
    update(32'h1100, 1'b1, 32'h3000);
    predict("alias_old", 32'h1000, 1'b0, 32'h1004);
    predict("alias_new", 32'h1100, 1'b1, 32'h3000);
    update(32'h1100, 1'b1, 32'h3400);
    predict("retarget", 32'h1100, 1'b1, 32'h3400);
    update(32'h2000, 1'b0, 32'h7000);
    predict("miss_nt", 32'h1100, 1'b1, 32'h3400);

    // perf_hits gating by valid/ready
    pc = 32'h1100; valid = 1'b1; ready = 1'b0;
    tick();
    check("perf_noready", 64'(perf_hits), 64'd1);
    ready = 1'b1;
    tick();
    check("perf_hit", 64'(perf_hits), 64'd2);
    pc = 32'h1234;
    tick();
    check("perf_miss", 64'(perf_hits), 64'd2);
    valid = 1'b0; ready = 1'b0;

    // same-cycle lookup/update to one idx sees the old entry
    upd_pc = 32'h1000; upd_taken = 1'b1; upd_target = 32'h5000; upd_valid = 1'b1;
    predict("bypass_old", 32'h1100, 1'b1, 32'h3400);
    tick();
    upd_valid = 1'b0;
    predict("bypass_after_old", 32'h1100, 1'b0, 32'h1104);
    predict("bypass_after_new", 32'h1000, 1'b1, 32'h5000);

    // flush beats a simultaneous update; perf_hits survives
    update(32'h1804, 1'b1, 32'h6000);
    predict("pre_flush", 32'h1804, 1'b1, 32'h6000);
    flush = 1'b1;
    update(32'h1808, 1'b1, 32'h6100);
    flush = 1'b0;
    predict("flush_a", 32'h1000, 1'b0, 32'h1004);
    predict("flush_b", 32'h1804, 1'b0, 32'h1808);
    predict("flush_upd", 32'h1808, 1'b0, 32'h180C);
    check("flush.perf", 64'(perf_hits), 64'd2);

    // reset mid-operation dominates a simultaneous update
    update(32'h1000, 1'b1, 32'h2000);
    predict("pre_rst", 32'h1000, 1'b1, 32'h2000);
    rst = 1'b1;
    update(32'h1804, 1'b1, 32'h6000);
    rst = 1'b0;
    predict("rst_a", 32'h1000, 1'b0, 32'h1004);
    predict("rst_upd", 32'h1804, 1'b0, 32'h1808);
    check("rst.perf", 64'(perf_hits), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
